mfp_ahb_master_arbiter: RTL and testbench
=========================================

// Module: mfp_ahb_master_arbiter
// PURPOSE
//  Two-master AHB-Lite arbiter placed in front of mfp_ahb, sharing the slave bus between the CPU (M0) and the SREC loader bridge (M1).
//  It serialises bus ownership on transfer boundaries and stalls the CPU through m0_HREADY.
//  The loader has no HREADY input, so its write transfers are queued in a small FIFO and replayed when the loader holds the grant.
//  It also drives the CPU reset hold for the whole load.
// PARAMETERS
//  FIFO_DEPTH  4  loader write-queue entries; must be a power of two, at least 2
//  FIFO_AW     2  log2(FIFO_DEPTH)
// PORTS
//  HCLK            in   1   system clock, single clock domain
//  HRESETn         in   1   reset, asynchronous, active-low
//  loader_active   in   1   SREC parser in_progress
//  m0_HADDR/HBURST/HMASTLOCK/HPROT/HSIZE/HTRANS/HWDATA/HWRITE  in  32/3/1/4/3/2/32/1  CPU master request
//  m0_HRDATA       out  32  read data returned to the CPU
//  m0_HREADY       out  1   ready returned to the CPU
//  m0_HRESP        out  1   response returned to the CPU
//  m1_HADDR/HSIZE/HTRANS/HWDATA/HWRITE  in  32/3/2/32/1  loader master; writes only, never stalls
//  HADDR/HBURST/HMASTLOCK/HPROT/HSIZE/HTRANS/HWDATA/HWRITE  out  (as m0)  slave-side request to mfp_ahb
//  HRDATA          in   32  slave read data
//  HREADY          in   1   slave ready
//  HRESP           in   1   slave response
//  cpu_reset_hold  out  1   CPU held in reset while a load is running
//  loader_overflow out  1   sticky flag: a loader write was lost
//  fifo_level      out  FIFO_AW+1  number of queued loader writes
// BEHAVIOUR
//  Reset values:
//   - state=CPU, dp_owner=CPU, FIFO empty
//   - HTRANS=IDLE, m0_HREADY=1, cpu_reset_hold=0, loader_overflow=0, fifo_level=0
//  Loader capture (runs in every state):
//   - Cycle t, m1_HTRANS==NONSEQ with HWRITE=1: latch HADDR and HSIZE.
//   - Cycle t+1: take m1_HWDATA and push {addr,size,data}.
//   - Push while the FIFO is full drops the entry and sets loader_overflow (cleared only by reset).
//   - A simultaneous push and pop is legal and leaves the level unchanged.
//   - m1 transfers with HWRITE=0 are ignored.
//  Address phase is accepted when HREADY=1. dp_owner is updated on acceptance and selects the slave HWDATA source:
//   - m0_HWDATA when dp_owner is CPU;
//   - the data latched from the popped entry when dp_owner is the loader.
//  FSM:
//   - CPU: m0 request forwarded unchanged; m0_HREADY=HREADY; m0_HRDATA=HRDATA; m0_HRESP=HRESP.
//     Go to DRAIN on loader_active=1 or fifo_level!=0.
//   - DRAIN: slave HTRANS forced to IDLE, m0_HREADY=HREADY while the CPU data phase is in flight, then 0.
//     The CPU holds its pending address. Go to LOAD on the first HREADY=1 cycle with no CPU data phase outstanding.
//   - LOAD: drive the FIFO head as NONSEQ WRITE (HBURST=SINGLE, HPROT=4'b0011, HMASTLOCK=0).
//     Pop when HREADY=1. Drive IDLE when the FIFO is empty. m0_HREADY=0.
//     Go to HANDBACK when loader_active=0, FIFO empty and no loader data phase is outstanding.
//   - HANDBACK: one IDLE cycle, m0_HREADY=0, then go to CPU. The CPU address is re-presented and forwarded normally.
//  Error response:
//   - HRESP=1 during a loader data phase is absorbed; the arbiter does not retry and continues with the next entry.
//   - HRESP=1 during a CPU data phase passes to m0_HRESP.
//  cpu_reset_hold = 1 from the cycle after loader_active rises until the cycle HANDBACK exits.
//  A loader_active pulse with no writes still goes DRAIN -> LOAD -> HANDBACK -> CPU.
//  Asynchronous reset mid-load: all state, FIFO contents and the flags clear immediately.
// TESTING
//  1. No loader activity; CPU reads/writes with HREADY=1 -> slave bus equals m0 each cycle, m0_HREADY=1.
//  2. CPU write to 0x1F80_0000 in data phase when loader_active rises -> data phase completes with HWDATA=m0_HWDATA, then HTRANS=IDLE, m0_HREADY=0.
//  3. Loader writes 0x1234_5678 to 0x0000_0010 then 0xCAFE_F00D to 0x0000_0014, slave HREADY=1 -> both appear on the slave in order, 1 cycle apart, fifo_level returns to 0.
//  4. Slave HREADY held 0 for 20 cycles while the loader pushes 5 writes -> 4 kept, loader_overflow=1, fifo_level=4.
//  5. loader_active falls with 2 entries queued -> both drained, one IDLE cycle, then the CPU's held fetch is forwarded and cpu_reset_hold drops.
//  6. HRESETn low while in LOAD with 3 entries queued -> HTRANS=IDLE, fifo_level=0, state CPU, m0_HREADY=1.

Source files
------------

// File: rtl/mfp_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_ahb_master_arbiter
//  Description : Two-master AHB-Lite arbiter (CPU + SREC loader) with a loader
//                write queue and CPU reset hold for the duration of a load.
//  Revision    : 1.0
// ============================================================================
module mfp_ahb_master_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 loader_active,
    input  logic [31:0]          m0_HADDR,
    input  logic [2:0]           m0_HBURST,
    input  logic                 m0_HMASTLOCK,
    input  logic [3:0]           m0_HPROT,
    input  logic [2:0]           m0_HSIZE,
    input  logic [1:0]           m0_HTRANS,
    input  logic [31:0]          m0_HWDATA,
    input  logic                 m0_HWRITE,
    output logic [31:0]          m0_HRDATA,
    output logic                 m0_HREADY,
    output logic                 m0_HRESP,
    input  logic [31:0]          m1_HADDR,
    input  logic [2:0]           m1_HSIZE,
    input  logic [1:0]           m1_HTRANS,
    input  logic [31:0]          m1_HWDATA,
    input  logic                 m1_HWRITE,
    output logic [31:0]          HADDR,
    output logic [2:0]           HBURST,
    output logic                 HMASTLOCK,
    output logic [3:0]           HPROT,
    output logic [2:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic [31:0]          HWDATA,
    output logic                 HWRITE,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 cpu_reset_hold,
    output logic                 loader_overflow,
    output logic [FIFO_AW:0]     fifo_level
);

    typedef enum logic [1:0] {
        S_CPU      = 2'd0,
        S_DRAIN    = 2'd1,
        S_LOAD     = 2'd2,
        S_HANDBACK = 2'd3
    } state_t;

    localparam logic [1:0]         c_htrans_idle   = 2'b00;
    localparam logic [1:0]         c_htrans_nonseq = 2'b10;
    localparam logic [FIFO_AW:0]   c_fifo_full     = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   c_lvl_one       = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] c_ptr_one       = FIFO_AW'(1);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_cap_pend;
    logic [31:0]           r_cap_addr;
    logic [2:0]            r_cap_size;

    logic [31:0]           r_fifo_addr [FIFO_DEPTH];
    logic [2:0]            r_fifo_size [FIFO_DEPTH];
    logic [31:0]           r_fifo_data [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_level;

    logic                  r_overflow;
    logic                  r_hold;
    logic                  r_dp_valid;
    logic                  r_dp_owner;   // 1 = loader owns the data phase
    logic [31:0]           r_dp_wdata;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_cpu_dp;
    logic                  w_ldr_dp_busy;

    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == c_fifo_full);
    assign w_pop         = (r_state == S_LOAD) && !w_empty && HREADY;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_ok     = r_cap_pend && (!w_full || w_pop);
    assign w_cpu_dp      = r_dp_valid && !r_dp_owner;
    assign w_ldr_dp_busy = r_dp_valid && r_dp_owner && !HREADY;

    assign HWDATA          = r_dp_owner ? r_dp_wdata : m0_HWDATA;
    assign m0_HRDATA       = HRDATA;
    assign cpu_reset_hold  = r_hold;
    assign loader_overflow = r_overflow;
    assign fifo_level      = r_level;

    // Loader capture: address phase latched, data taken one cycle later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cap_pend <= 1'b0;
            r_cap_addr <= '0;
            r_cap_size <= '0;
        end else begin
            r_cap_pend <= (m1_HTRANS == c_htrans_nonseq) && m1_HWRITE;
            if ((m1_HTRANS == c_htrans_nonseq) && m1_HWRITE) begin
                r_cap_addr <= m1_HADDR;
                r_cap_size <= m1_HSIZE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_size[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo_addr[r_wr_ptr] <= r_cap_addr;
                r_fifo_size[r_wr_ptr] <= r_cap_size;
                r_fifo_data[r_wr_ptr] <= m1_HWDATA;
                r_wr_ptr              <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + c_lvl_one;
            end else if (!w_push_ok && w_pop) begin
                r_level <= r_level - c_lvl_one;
            end
            if (r_cap_pend && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_CPU;
            r_hold     <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_owner <= 1'b0;
            r_dp_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (loader_active) begin
                r_hold <= 1'b1;
            end else if (r_state == S_HANDBACK) begin
                r_hold <= 1'b0;
            end
            if (HREADY) begin
                r_dp_valid <= HTRANS[1];
                r_dp_owner <= (r_state == S_LOAD);
                if (w_pop) begin
                    r_dp_wdata <= r_fifo_data[r_rd_ptr];
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        HADDR        = m0_HADDR;
        HBURST       = m0_HBURST;
        HMASTLOCK    = m0_HMASTLOCK;
        HPROT        = m0_HPROT;
        HSIZE        = m0_HSIZE;
        HWRITE       = m0_HWRITE;
        HTRANS       = c_htrans_idle;
        m0_HREADY    = 1'b0;
        m0_HRESP     = 1'b0;
        case (r_state)
            S_CPU: begin
                HTRANS    = m0_HTRANS;
                m0_HREADY = HREADY;
                m0_HRESP  = HRESP;
                if (loader_active || !w_empty) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_cpu_dp) begin
                    m0_HREADY = HREADY;
                    m0_HRESP  = HRESP;
                end else if (HREADY) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                // Loader error responses are absorbed; the queue simply moves on.
                if (!w_empty) begin
                    HADDR     = r_fifo_addr[r_rd_ptr];
                    HSIZE     = r_fifo_size[r_rd_ptr];
                    HTRANS    = c_htrans_nonseq;
                    HWRITE    = 1'b1;
                    HBURST    = 3'b000;
                    HPROT     = 4'b0011;
                    HMASTLOCK = 1'b0;
                end
                if (!loader_active && w_empty && !r_cap_pend && !w_ldr_dp_busy) begin
                    w_next_state = S_HANDBACK;
                end
            end
            S_HANDBACK: begin
                w_next_state = S_CPU;
            end
            default: begin
                w_next_state = S_CPU;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfp_ahb_master_arbiter
//  Description : Directed scoreboard bench for the CPU/loader AHB arbiter.
//  Revision    : 1.0
// ============================================================================
module tb_mfp_ahb_master_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        chk_rd;
    } exp_t;

    logic        HCLK;
    logic        HRESETn;
    logic        loader_active;
    logic [31:0] m0_HADDR;
    logic [2:0]  m0_HBURST;
    logic        m0_HMASTLOCK;
    logic [3:0]  m0_HPROT;
    logic [2:0]  m0_HSIZE;
    logic [1:0]  m0_HTRANS;
    logic [31:0] m0_HWDATA;
    logic        m0_HWRITE;
    logic [31:0] m0_HRDATA;
    logic        m0_HREADY;
    logic        m0_HRESP;
    logic [31:0] m1_HADDR;
    logic [2:0]  m1_HSIZE;
    logic [1:0]  m1_HTRANS;
    logic [31:0] m1_HWDATA;
    logic        m1_HWRITE;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        cpu_reset_hold;
    logic        loader_overflow;
    logic [2:0]  fifo_level;

    int          tests_run;
    int          tests_failed;
    exp_t        sb[$];
    logic [31:0] ld_data [0:7];
    logic [31:0] sl_addr;
    logic        mon_pend;
    logic [31:0] mon_addr;
    logic        mon_wr;
    int          cnt;

    mfp_ahb_master_arbiter #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .loader_active(loader_active),
        .m0_HADDR(m0_HADDR), .m0_HBURST(m0_HBURST), .m0_HMASTLOCK(m0_HMASTLOCK),
        .m0_HPROT(m0_HPROT), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
        .m0_HWDATA(m0_HWDATA), .m0_HWRITE(m0_HWRITE),
        .m0_HRDATA(m0_HRDATA), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
        .m1_HADDR(m1_HADDR), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
        .m1_HWDATA(m1_HWDATA), .m1_HWRITE(m1_HWRITE),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .cpu_reset_hold(cpu_reset_hold), .loader_overflow(loader_overflow),
        .fifo_level(fifo_level)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: read data is a fixed function of the accepted address.
    always @(posedge HCLK) begin
        if (HREADY && HTRANS[1]) sl_addr <= HADDR;
    end
    assign HRDATA = sl_addr ^ 32'h5A5A_5A5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed slave data phase is matched against the queue head.
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESETn) begin
            mon_pend <= 1'b0;
        end else if (HREADY) begin
            if (mon_pend) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_underflow: unexpected transfer at %h", mon_addr);
                end else begin
                    e = sb.pop_front();
                    check("sb_addr", mon_addr, e.addr);
                    check("sb_write", {31'd0, mon_wr}, {31'd0, e.wr});
                    if (e.wr) check("sb_hwdata", HWDATA, e.data);
                    if (e.chk_rd) check("sb_rdata", m0_HRDATA, e.data);
                end
            end
            mon_pend <= HTRANS[1];
            mon_addr <= HADDR;
            mon_wr   <= HWRITE;
        end
    end

    task automatic cpu_cycle(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                             input logic [31:0] wd);
        @(posedge HCLK); #1;
        m0_HTRANS = tr; m0_HADDR = a; m0_HWRITE = wr; m0_HWDATA = wd;
        @(negedge HCLK);
        check("t1_haddr", HADDR, a);
        check("t1_htrans", {30'd0, HTRANS}, {30'd0, tr});
        check("t1_hwdata", HWDATA, wd);
        check("t1_m0_hready", {31'd0, m0_HREADY}, 32'd1);
    endtask

    // Pipelined loader writes: address of entry i overlaps data of entry i-1.
    task automatic loader_burst(input int n, input int keep, input logic [31:0] base_a);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
            m1_HTRANS = 2'b10; m1_HWRITE = 1'b1; m1_HSIZE = 3'd2;
            m1_HADDR  = base_a + 32'(4 * i);
            if (i > 0) m1_HWDATA = ld_data[i-1];
            if (i < keep) sb.push_back('{base_a + 32'(4 * i), ld_data[i], 1'b1, 1'b0});
        end
        @(posedge HCLK); #1;
        m1_HTRANS = 2'b00; m1_HWRITE = 1'b0; m1_HWDATA = ld_data[n-1];
        @(posedge HCLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        HRESETn = 1'b0; loader_active = 1'b0;
        m0_HADDR = '0; m0_HBURST = '0; m0_HMASTLOCK = 1'b0; m0_HPROT = 4'b0011;
        m0_HSIZE = 3'd2; m0_HTRANS = 2'b00; m0_HWDATA = '0; m0_HWRITE = 1'b0;
        m1_HADDR = '0; m1_HSIZE = '0; m1_HTRANS = 2'b00; m1_HWDATA = '0; m1_HWRITE = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_m0_hready", {31'd0, m0_HREADY}, 32'd1);
        check("rst_hold", {31'd0, cpu_reset_hold}, 32'd0);
        check("rst_overflow", {31'd0, loader_overflow}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // CPU-only traffic is forwarded untouched.
        sb.push_back('{32'h0000_0100, 32'h1111_1111, 1'b1, 1'b0});
        cpu_cycle(2'b10, 32'h0000_0100, 1'b1, 32'h0000_0000);
        sb.push_back('{32'h0000_0104, 32'h0000_0104 ^ 32'h5A5A_5A5A, 1'b0, 1'b1});
        cpu_cycle(2'b10, 32'h0000_0104, 1'b0, 32'h1111_1111);
        sb.push_back('{32'h0000_0108, 32'h2222_2222, 1'b1, 1'b0});
        cpu_cycle(2'b10, 32'h0000_0108, 1'b1, 32'h0000_0000);
        cpu_cycle(2'b00, 32'h0000_0108, 1'b0, 32'h2222_2222);
        @(posedge HCLK); #1; HRESP = 1'b1;
        @(negedge HCLK);
        check("t1_cpu_hresp", {31'd0, m0_HRESP}, 32'd1);
        @(posedge HCLK); #1; HRESP = 1'b0;

        // Loader reads are ignored.
        m1_HTRANS = 2'b10; m1_HWRITE = 1'b0; m1_HADDR = 32'h30;
        @(posedge HCLK); #1; m1_HTRANS = 2'b00;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("m1_read_level", {29'd0, fifo_level}, 32'd0);
        check("m1_read_m0_hready", {31'd0, m0_HREADY}, 32'd1);

        // Test 2: loader_active rises during a CPU write data phase.
        @(posedge HCLK); #1;
        m0_HTRANS = 2'b10; m0_HADDR = 32'h1F80_0000; m0_HWRITE = 1'b1;
        sb.push_back('{32'h1F80_0000, 32'hDEAD_BEEF, 1'b1, 1'b0});
        @(posedge HCLK); #1;
        m0_HTRANS = 2'b00; m0_HWDATA = 32'hDEAD_BEEF; loader_active = 1'b1;
        @(negedge HCLK);
        check("t2_hwdata", HWDATA, 32'hDEAD_BEEF);
        check("t2_dp_m0_hready", {31'd0, m0_HREADY}, 32'd1);
        @(posedge HCLK); #1;
        m0_HTRANS = 2'b10; m0_HADDR = 32'hBFC0_0000; m0_HWRITE = 1'b0;
        @(negedge HCLK);
        check("t2_htrans_idle", {30'd0, HTRANS}, 32'd0);
        check("t2_m0_hready", {31'd0, m0_HREADY}, 32'd0);
        check("t2_hold", {31'd0, cpu_reset_hold}, 32'd1);

        // Test 3: two loader writes, error responses absorbed.
        @(posedge HCLK); #1; HRESP = 1'b1;
        ld_data[0] = 32'h1234_5678; ld_data[1] = 32'hCAFE_F00D;
        loader_burst(2, 2, 32'h0000_0010);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("t3_level", {29'd0, fifo_level}, 32'd0);
        check("t3_m0_hresp", {31'd0, m0_HRESP}, 32'd0);
        check("t3_m0_hready", {31'd0, m0_HREADY}, 32'd0);
        @(posedge HCLK); #1; HRESP = 1'b0;

        // Test 4: slave stalled, five pushes into a four-entry queue.
        HREADY = 1'b0;
        for (int i = 0; i < 5; i++) ld_data[i] = 32'hA000_0000 + 32'(i);
        loader_burst(5, 4, 32'h0000_0020);
        repeat (13) @(posedge HCLK);
        @(negedge HCLK);
        check("t4_level", {29'd0, fifo_level}, 32'd4);
        check("t4_overflow", {31'd0, loader_overflow}, 32'd1);
        @(posedge HCLK); #1; HREADY = 1'b1;
        repeat (6) @(posedge HCLK);
        @(negedge HCLK);
        check("t4_drained", {29'd0, fifo_level}, 32'd0);

        // Test 5: loader finishes with two entries queued; CPU fetch resumes.
        @(posedge HCLK); #1; HREADY = 1'b0;
        ld_data[0] = 32'hB000_0040; ld_data[1] = 32'hB000_0044;
        loader_burst(2, 2, 32'h0000_0040);
        @(negedge HCLK);
        check("t5_level", {29'd0, fifo_level}, 32'd2);
        check("t5_hold_on", {31'd0, cpu_reset_hold}, 32'd1);
        @(posedge HCLK); #1; loader_active = 1'b0;
        sb.push_back('{32'hBFC0_0000, 32'hBFC0_0000 ^ 32'h5A5A_5A5A, 1'b0, 1'b1});
        @(posedge HCLK); #1; HREADY = 1'b1;
        cnt = 0;
        @(negedge HCLK);
        while (!m0_HREADY && cnt < 20) begin
            @(negedge HCLK);
            cnt++;
        end
        check("t5_handback_cycles", 32'(cnt), 32'd4);
        check("t5_fetch_htrans", {30'd0, HTRANS}, 32'd2);
        check("t5_fetch_haddr", HADDR, 32'hBFC0_0000);
        check("t5_hold_off", {31'd0, cpu_reset_hold}, 32'd0);
        @(posedge HCLK); #1; m0_HTRANS = 2'b00;
        @(posedge HCLK); #1;

        // Test 6: asynchronous reset in LOAD with three entries queued.
        loader_active = 1'b1;
        repeat (3) @(posedge HCLK);
        #1; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) ld_data[i] = 32'hC000_0000 + 32'(i);
        loader_burst(3, 0, 32'h0000_0080);
        @(negedge HCLK);
        check("t6_level_before", {29'd0, fifo_level}, 32'd3);
        @(posedge HCLK); #2;
        HREADY = 1'b1; loader_active = 1'b0; HRESETn = 1'b0;
        #1;
        check("t6_htrans", {30'd0, HTRANS}, 32'd0);
        check("t6_level", {29'd0, fifo_level}, 32'd0);
        check("t6_m0_hready", {31'd0, m0_HREADY}, 32'd1);
        check("t6_overflow", {31'd0, loader_overflow}, 32'd0);
        check("t6_hold", {31'd0, cpu_reset_hold}, 32'd0);
        @(posedge HCLK); #1; HRESETn = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("t6_post_m0_hready", {31'd0, m0_HREADY}, 32'd1);
        check("t6_post_htrans", {30'd0, HTRANS}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
